// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: WIDTH+1 cycles from start to valid, 1 cycle for divide-by-zero/overflow.
// Backpressure: none; busy stalls the pipeline, start is ignored unless IDLE, flush aborts.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start_EX,
   input  logic [1:0]       i_div_op_EX,
   input  logic [WIDTH-1:0] i_rd1_EX,
   input  logic [WIDTH-1:0] i_rd2_EX,
   input  logic             i_flush_EX,
   output logic             o_busy_EX,
   output logic             o_valid_EX,
   output logic [WIDTH-1:0] o_div_result_EX
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             valid;

   // op[0]=1 means unsigned, op[1]=1 selects the remainder
   logic             op_signed;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_zero, div_ovf;
   logic [WIDTH:0]   shifted, diff;
   logic [WIDTH-1:0] fix_quo, fix_rem, done_res;

   assign op_signed = ~i_div_op_EX[0];
   assign a_neg     = op_signed & i_rd1_EX[WIDTH-1];
   assign b_neg     = op_signed & i_rd2_EX[WIDTH-1];
   assign a_mag     = a_neg ? -i_rd1_EX : i_rd1_EX;
   assign b_mag     = b_neg ? -i_rd2_EX : i_rd2_EX;
   assign div_zero  = (i_rd2_EX == '0);
   assign div_ovf   = op_signed & (i_rd1_EX == MIN_NEG) & (i_rd2_EX == '1);

   // One restoring step: the extra top bit of the difference is the borrow
   assign shifted   = {rem_q, quo_q[WIDTH-1]};
   assign diff      = shifted - {1'b0, dvs_q};

   // Sign fix applied while in DONE; special cases load zero sign flags
   assign fix_quo   = qneg_q ? -quo_q : quo_q;
   assign fix_rem   = rneg_q ? -rem_q : rem_q;
   assign done_res  = op_q[1] ? fix_rem : fix_quo;

   // Next-state, datapath and output decode
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      res_d   = res_q;
      valid   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start_EX) begin
               op_d = i_div_op_EX;
               if (div_zero) begin
                  quo_d   = '1;
                  rem_d   = i_rd1_EX;
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = DONE;
               end else if (div_ovf) begin
                  quo_d   = MIN_NEG;
                  rem_d   = '0;
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  quo_d   = a_mag;
                  rem_d   = '0;
                  dvs_d   = b_mag;
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
                  cnt_d   = CW'(WIDTH-1);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (diff[WIDTH]) begin
               rem_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
               rem_d = diff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            valid   = 1'b1;
            res_d   = done_res;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Flush wins over everything: back to IDLE, no pulse, result untouched
      if (i_flush_EX) begin
         state_d = IDLE;
         valid   = 1'b0;
         res_d   = res_q;
      end
   end

   assign o_busy_EX       = (state_q != IDLE);
   assign o_valid_EX      = valid;
   assign o_div_result_EX = valid ? done_res : res_q;

   // State and datapath registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: cycle-level behavioural model plus directed literal cases.
// Latency: model predicts busy/valid/result for every cycle after the first reset.
// Backpressure: random start/flush traffic exercises ignored starts and aborts.
module tb_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         flush;
   logic         busy, valid;
   logic [W-1:0] result;

   int checks = 0;
   int failures = 0;

   div_unit #(.WIDTH(W)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start_EX     (start),
      .i_div_op_EX    (op),
      .i_rd1_EX       (a),
      .i_rd2_EX       (b),
      .i_flush_EX     (flush),
      .o_busy_EX      (busy),
      .o_valid_EX     (valid),
      .o_div_result_EX(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // RISC-V M-extension semantics in plain arithmetic
   function automatic logic [31:0] ref_fn(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      case (o)
         2'b00:   return 32'(sx / sy);
         2'b01:   return x / y;
         2'b10:   return 32'(sx % sy);
         default: return x % y;
      endcase
   endfunction

   function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
   endfunction

   // Timeline model: m_left = cycles remaining up to and including the valid cycle
   int           m_left = 0;
   bit           m_live = 0;
   logic [31:0]  m_pend = '0;
   logic [31:0]  m_last = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_left = 0;
         m_last = '0;
         m_live = 1;
      end else if (flush) begin
         m_left = 0;
      end else if (m_left == 0) begin
         if (start) begin
            m_pend = ref_fn(op, a, b);
            m_left = is_special(op, a, b) ? 1 : W + 1;
         end
      end else begin
         if (m_left == 1) m_last = m_pend;
         m_left--;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_live) begin
         logic ev;
         ev = (m_left == 1) && !flush;
         chk("busy", {31'b0, busy}, {31'b0, m_left != 0});
         chk("valid", {31'b0, valid}, {31'b0, ev});
         chk("result", result, ev ? m_pend : m_last);
      end
   end

   task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
      bit got;
      int lat;
      logic [31:0] r;
      got = 0; lat = 0; r = '0;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (valid) begin
            got = 1; lat = c; r = result;
            break;
         end
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL %s_timeout: no valid within 40 cycles", nm);
      end else begin
         chk({nm, "_lat"}, lat, exp_lat);
         chk({nm, "_res"}, r, exp);
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int npulse, pcyc, rvalid;
      logic [31:0] pres;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_valid", {31'b0, valid}, 32'h0);
      chk("rst_result", result, 32'h0);
      rst_n = 1'b1;

      // pin the reference function with hand-computed values
      chk("ref_divu", ref_fn(2'b01, 32'd100, 32'd7), 32'h0000_000E);
      chk("ref_div_neg", ref_fn(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      chk("ref_rem_neg", ref_fn(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      chk("ref_rem_zero", ref_fn(2'b10, 32'hFFFF_FFF9, 32'd0), 32'hFFFF_FFF9);

      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000_000E, 33);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 33);
      run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33);
      run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'h0000_0005, 1);
      run_op("div_m7_0", 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("rem_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_op("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

      // start while busy is ignored
      npulse = 0; pcyc = 0; pres = '0;
      start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (valid) begin
            npulse++; pcyc = c; pres = result;
         end
         if (c == 4) begin start = 1'b1; a = 32'd9; b = 32'd3; end
         if (c == 5) start = 1'b0;
      end
      chk("busy_start_pulses", npulse, 1);
      chk("busy_start_cycle", pcyc, 33);
      chk("busy_start_res", pres, 32'h0000_0064);
      @(posedge clk); #1;

      // flush mid-divide, then restart
      npulse = 0;
      start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h11;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (valid) npulse++;
         if (c == 10) flush = 1'b1;
         if (c == 11) begin
            chk("flush_idle", {31'b0, busy}, 32'h0);
            chk("flush_hold", result, 32'h0000_0064);
            flush = 1'b0;
         end
      end
      chk("flush_no_pulse", npulse, 0);
      @(posedge clk); #1;
      run_op("after_flush", 2'b01, 32'd9, 32'd3, 32'h0000_0003, 33);

      // reset mid-operation
      start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 20; c++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {31'b0, busy}, 32'h0);
      chk("midrst_valid", {31'b0, valid}, 32'h0);
      chk("midrst_result", result, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("after_rst", 2'b01, 32'd1, 32'd1, 32'h0000_0001, 33);

      // random traffic checked cycle by cycle by the model
      rvalid = 0;
      for (int i = 0; i < 5000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 63) == 0);
         op    = 2'($urandom_range(0, 3));
         a     = pick();
         b     = pick();
         @(negedge clk);
         if (valid) rvalid++;
         @(posedge clk); #1;
      end
      start = 1'b0; flush = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("rand_activity", {31'b0, rvalid > 20}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
